demux_1_to_4_stream: RTL and testbench



---
 rtl/demux_pkg.sv | 20 ++
 rtl/demux_lane_reg.sv | 33 +++
 rtl/demux_1_to_4_stream.sv | 95 +++++++++
 tb/tb_demux_1_to_4_stream.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-4 stream demultiplexer.
// Lane count, select width, round-robin state encoding and statistics counter sizing.
package demux_pkg;

  localparam int LANES  = 4;
  localparam int SEL_W  = 2;
  localparam int STAT_W = 8;
  localparam logic [STAT_W-1:0] STAT_MAX = 8'hFF;

  typedef logic [SEL_W-1:0] lane_idx_t;

  // Encoding matches the lane index so the state drives rr_ptr directly.
  typedef enum logic [SEL_W-1:0] {
    P0 = 2'd0,
    P1 = 2'd1,
    P2 = 2'd2,
    P3 = 2'd3
  } rr_state_t;

endpackage

// File: rtl/demux_lane_reg.sv
// One-entry valid/ready output register for a single demux lane.
// A load in the same cycle as a drain replaces the old beat, giving one beat per cycle.
module demux_lane_reg
  import demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             free
);

  assign free = !valid || ready;

  // Data is not cleared on drain; only valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_1_to_4_stream.sv
// Registered 1-to-4 valid/ready demultiplexer with select or round-robin routing.
// Optional per-lane saturating beat counters are built when DEMUX_STATS_EN is defined.
module demux_1_to_4_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   rr_mode,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [LANES-1:0]       out_valid,
  input  logic [LANES-1:0]       out_ready,
  output logic [SEL_W-1:0]       rr_ptr
`ifdef DEMUX_STATS_EN
  ,
  input  logic                   stats_clr,
  output logic [LANES*STAT_W-1:0] lane_count
`endif
);

  rr_state_t         state;
  rr_state_t         state_next;
  lane_idx_t         dst;
  logic [LANES-1:0]  lane_free;
  logic [LANES-1:0]  load;
  logic              accept;

  assign rr_ptr   = state;
  assign dst      = rr_mode ? lane_idx_t'(state) : in_sel;
  // Gating with rst_n keeps in_ready low throughout reset.
  assign in_ready = rst_n && lane_free[dst];
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= P0;
    end else begin
      state <= state_next;
    end
  end

  // The pointer moves only on round-robin accepts; a full lane stalls it in place.
  always_comb begin
    state_next = state;
    if (accept && rr_mode) begin
      case (state)
        P0:      state_next = P1;
        P1:      state_next = P2;
        P2:      state_next = P3;
        P3:      state_next = P0;
        default: state_next = P0;
      endcase
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign load[k] = accept && (dst == lane_idx_t'(k));

    demux_lane_reg #(
      .WIDTH(WIDTH)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load[k]),
      .load_data(in_data),
      .ready    (out_ready[k]),
      .valid    (out_valid[k]),
      .data     (out_data[k*WIDTH +: WIDTH]),
      .free     (lane_free[k])
    );

`ifdef DEMUX_STATS_EN
    logic [STAT_W-1:0] cnt;

    // Clear has priority over a coincident accept.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
      end else if (stats_clr) begin
        cnt <= '0;
      end else if (load[k] && (cnt != STAT_MAX)) begin
        cnt <= cnt + 1'b1;
      end
    end

    assign lane_count[k*STAT_W +: STAT_W] = cnt;
`endif
  end

endmodule

// File: tb/tb_demux_1_to_4_stream.sv
// Self-checking bench for demux_1_to_4_stream using per-lane expected-beat queues.
// Stats checks are compiled in when DEMUX_STATS_EN is defined.
module tb_demux_1_to_4_stream;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic        rr_mode;
  logic [31:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [1:0]  rr_ptr;
`ifdef DEMUX_STATS_EN
  logic        stats_clr;
  logic [31:0] lane_count;
  logic [7:0]  mcnt [4];
`endif

  int total;
  int bad;

  logic [7:0] sb [4][$];
  logic [1:0] mptr;

  demux_1_to_4_stream #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rr_mode   (rr_mode),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rr_ptr    (rr_ptr)
`ifdef DEMUX_STATS_EN
    ,
    .stats_clr (stats_clr),
    .lane_count(lane_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clearModel();
    for (int k = 0; k < 4; k++) sb[k].delete();
    mptr = 2'd0;
`ifdef DEMUX_STATS_EN
    for (int k = 0; k < 4; k++) mcnt[k] = 8'd0;
`endif
  endtask

  // One cycle: check outputs against the model, drive inputs, check in_ready, update the model at the edge.
  task automatic applyStimulus(input logic rst, input logic v, input logic [7:0] d,
                               input logic [1:0] s, input logic rrm, input logic [3:0] rdy);
    logic [3:0] exp_valid;
    logic [1:0] dst;
    logic       exp_ready;
    logic       acc;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      exp_valid[k] = (sb[k].size() != 0);
      if (exp_valid[k]) checkOutput($sformatf("lane%0d_data", k), {24'd0, out_data[k*8 +: 8]}, {24'd0, sb[k][0]});
    end
    checkOutput("out_valid", {28'd0, out_valid}, {28'd0, exp_valid});
    checkOutput("rr_ptr", {30'd0, rr_ptr}, {30'd0, mptr});
`ifdef DEMUX_STATS_EN
    checkOutput("lane_count", lane_count, {mcnt[3], mcnt[2], mcnt[1], mcnt[0]});
`endif
    rst_n     = rst;
    in_valid  = v;
    in_data   = d;
    in_sel    = s;
    rr_mode   = rrm;
    out_ready = rdy;
    #1;
    if (!rst) begin
      clearModel();
      checkOutput("async_clr", {28'd0, out_valid}, 32'd0);
    end
    dst       = rrm ? mptr : s;
    exp_ready = rst && ((sb[dst].size() == 0) || rdy[dst]);
    checkOutput("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
    acc = v && exp_ready;
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 4; k++)
        if (sb[k].size() != 0 && rdy[k]) void'(sb[k].pop_front());
      if (acc) begin
        sb[dst].push_back(d);
        if (rrm) mptr = mptr + 2'd1;
      end
`ifdef DEMUX_STATS_EN
      if (stats_clr) begin
        for (int k = 0; k < 4; k++) mcnt[k] = 8'd0;
      end else if (acc && mcnt[dst] != 8'hFF) begin
        mcnt[dst] = mcnt[dst] + 8'd1;
      end
`endif
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h00;
    in_sel    = 2'd0;
    rr_mode   = 1'b0;
    out_ready = 4'b0000;
`ifdef DEMUX_STATS_EN
    stats_clr = 1'b0;
`endif
    clearModel();

    // Reset held with a pending producer beat
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 8'h5A, 2'd1, 1'b0, 4'b1111);
    #1 checkOutput("rst_data", out_data, 32'd0);
    applyStimulus(1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 4'b1111);

    // Select routing
    applyStimulus(1'b1, 1'b1, 8'hA0, 2'd2, 1'b0, 4'b1111);
    applyStimulus(1'b1, 1'b1, 8'hB1, 2'd0, 1'b0, 4'b1111);
    applyStimulus(1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 4'b1111);
    applyStimulus(1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 4'b1111);

    // Backpressure on lane 1
    applyStimulus(1'b1, 1'b1, 8'h11, 2'd1, 1'b0, 4'b1101);
    applyStimulus(1'b1, 1'b1, 8'h22, 2'd1, 1'b0, 4'b1101);
    applyStimulus(1'b1, 1'b1, 8'h22, 2'd1, 1'b0, 4'b1101);
    applyStimulus(1'b1, 1'b1, 8'h22, 2'd1, 1'b0, 4'b1111);
    applyStimulus(1'b1, 1'b0, 8'h00, 2'd1, 1'b0, 4'b1111);
    applyStimulus(1'b1, 1'b0, 8'h00, 2'd1, 1'b0, 4'b1111);

    // Round-robin wrap
    for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 1'b1, 8'(i), 2'd3, 1'b1, 4'b1111);
    applyStimulus(1'b1, 1'b0, 8'h00, 2'd0, 1'b1, 4'b1111);

    // Round-robin stall on a full lane 3
    applyStimulus(1'b1, 1'b1, 8'h31, 2'd0, 1'b1, 4'b1111);
    applyStimulus(1'b1, 1'b1, 8'h32, 2'd0, 1'b1, 4'b1111);
    applyStimulus(1'b1, 1'b1, 8'h33, 2'd3, 1'b0, 4'b0111);
    applyStimulus(1'b1, 1'b1, 8'h34, 2'd0, 1'b1, 4'b0111);
    applyStimulus(1'b1, 1'b1, 8'h34, 2'd0, 1'b1, 4'b0111);
    applyStimulus(1'b1, 1'b1, 8'h34, 2'd0, 1'b1, 4'b1111);
    applyStimulus(1'b1, 1'b0, 8'h00, 2'd0, 1'b1, 4'b1111);

    // Random traffic with random consumers and mode changes
    for (int i = 0; i < 60; i++)
      applyStimulus(1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));

    // Reset mid-operation with beats buffered
    applyStimulus(1'b1, 1'b1, 8'h77, 2'd2, 1'b0, 4'b0000);
    applyStimulus(1'b0, 1'b1, 8'h78, 2'd2, 1'b1, 4'b0000);
    applyStimulus(1'b1, 1'b1, 8'h79, 2'd0, 1'b1, 4'b1111);
    applyStimulus(1'b1, 1'b0, 8'h00, 2'd0, 1'b1, 4'b1111);

`ifdef DEMUX_STATS_EN
    // Saturation and clear of the beat counters
    for (int i = 0; i < 300; i++) applyStimulus(1'b1, 1'b1, 8'(i), 2'd1, 1'b0, 4'b1111);
    stats_clr = 1'b1;
    applyStimulus(1'b1, 1'b1, 8'hC0, 2'd1, 1'b0, 4'b1111);
    stats_clr = 1'b0;
    applyStimulus(1'b1, 1'b0, 8'h00, 2'd1, 1'b0, 4'b1111);
    applyStimulus(1'b1, 1'b0, 8'h00, 2'd1, 1'b0, 4'b1111);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
